wb_regfile: RTL
===============

# wb_regfile

Writeback-stage consumer of the MEM/WB interstage register: selects the writeback value, commits it into a 32-entry general-purpose register file, and serves the two decode-stage read ports. It also keeps a committed-write counter used by the processor's debug and test benches. It sits at the tail of the pipeline and drives operands back into ID, closing the loop from MEM/WB.

## Interface

Parameters:
- DATA_WIDTH, 32, register and writeback data width
- ADDR_WIDTH, 5, register index width (2^ADDR_WIDTH entries)
- COUNT_WIDTH, 32, width of committed-write counter

Ports:
- clock  in  1  single clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low; low clears all state immediately
- memToRegRegister  in  1  from MEM/WB; 1 = write memOutRegister, 0 = write ALUOutRegister
- regWriteRegister  in  1  from MEM/WB; write enable
- rdRegister  in  ADDR_WIDTH  from MEM/WB; destination index
- memOutRegister  in  DATA_WIDTH  from MEM/WB; load data
- ALUOutRegister  in  DATA_WIDTH  from MEM/WB; ALU result
- rs  in  ADDR_WIDTH  read port A index (ID stage)
- rt  in  ADDR_WIDTH  read port B index (ID stage)
- rsData  out  DATA_WIDTH  read port A data
- rtData  out  DATA_WIDTH  read port B data
- wbData  out  DATA_WIDTH  selected writeback value, for EX forwarding
- writeCount  out  COUNT_WIDTH  number of committed register writes

## Operation

- wbData = memToRegRegister ? memOutRegister : ALUOutRegister; purely combinational, independent of regWriteRegister.
- Commit condition: regWriteRegister == 1 and rdRegister != 0. On commit, regs[rdRegister] <= wbData at rising clock edge.
- Register 0 is hardwired zero: never written, always reads 0, writes to it are not counted.
- Reads are combinational: rsData = regs[rs], rtData = regs[rt] (0 when index 0).
- writeCount increments by 1 on every committed write; wraps from 2^COUNT_WIDTH-1 to 0 silently.
- Both read ports may address the same register; both return the same value.
- X-free: all entries defined from reset onward.

## Timing

- reset low (asynchronous, any time, including mid-write): all registers 0, writeCount 0; therefore rsData, rtData read 0. wbData still follows inputs combinationally.
- reset deassertion: first commit possible on the first rising edge with reset high.
- Write latency: value visible on read ports after the committing edge (see Configuration for same-cycle visibility).
- Simultaneous commit and read of same index: behaviour governed by WB_BYPASS_EN.
- Commit with regWriteRegister low or rdRegister == 0: no state change, counter unchanged.
- One commit per cycle max; no back-pressure, no stall input (MEM/WB already handles flushes by zeroing regWriteRegister).

## Configuration

- WB_BYPASS_EN defined: write-through bypass. If commit condition holds and rs == rdRegister, rsData = wbData in the same cycle; likewise rtData when rt == rdRegister. Index 0 never bypassed. ID sees WB results without an extra stall.
- WB_BYPASS_EN undefined: reads return stored contents only; a same-cycle read of the register being written returns the old value until after the edge. Hazard unit must stall one extra cycle for WB→ID dependencies.

## Test plan

- Reset: pulse reset low mid-cycle after writing 0xDEADBEEF to r5 -> rsData(rs=5)=0 immediately, writeCount=0.
- Select/commit: memToReg=1, memOut=0x1234, ALUOut=0x5678, regWrite=1, rd=7, one edge -> wbData=0x1234 before edge, regs[7]=0x1234 after, writeCount=1; repeat with memToReg=0 -> regs[7]=0x5678, writeCount=2.
- r0 guard: regWrite=1, rd=0, ALUOut=0xFFFFFFFF -> rsData(rs=0)=0, writeCount unchanged; regWrite=0, rd=3 -> regs[3] unchanged.
- Bypass: regWrite=1, rd=9, ALUOut=0xCAFE, rs=rt=9 before edge -> with WB_BYPASS_EN both ports 0xCAFE same cycle; without, old value then 0xCAFE after edge.
- Dual read: regs[1]=0x11, regs[2]=0x22, rs=1, rt=2 -> rsData=0x11, rtData=0x22; rs=rt=2 -> both 0x22.
- Counter wrap: COUNT_WIDTH=4, 17 commits to rd=4 -> writeCount=1.

Source files
------------

// File: rtl/wb_regfile.sv
// Writeback select + 32-entry GPR file with committed-write counter; writes land on the clock edge, reads are combinational.
// No backpressure; WB_BYPASS_EN adds same-cycle write-through on both read ports.
module wb_regfile #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 5,
  parameter int COUNT_WIDTH = 32
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   memToRegRegister,
  input  logic                   regWriteRegister,
  input  logic [ADDR_WIDTH-1:0]  rdRegister,
  input  logic [DATA_WIDTH-1:0]  memOutRegister,
  input  logic [DATA_WIDTH-1:0]  ALUOutRegister,
  input  logic [ADDR_WIDTH-1:0]  rs,
  input  logic [ADDR_WIDTH-1:0]  rt,
  output logic [DATA_WIDTH-1:0]  rsData,
  output logic [DATA_WIDTH-1:0]  rtData,
  output logic [DATA_WIDTH-1:0]  wbData,
  output logic [COUNT_WIDTH-1:0] writeCount
);

  localparam int NUM_REGS = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic                  commit;

  assign wbData = memToRegRegister ? memOutRegister : ALUOutRegister;
  assign commit = regWriteRegister && (rdRegister != '0);

  // Entry 0 is cleared by reset and never committed, so it stays zero.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
      writeCount <= '0;
    end else if (commit) begin
      regs[rdRegister] <= wbData;
      writeCount       <= writeCount + COUNT_WIDTH'(1);
    end
  end

  always_comb begin
    rsData = '0;
    rtData = '0;
    if (rs != '0) rsData = regs[rs];
    if (rt != '0) rtData = regs[rt];
`ifdef WB_BYPASS_EN
    // commit already excludes index 0, so r0 is never bypassed.
    if (commit && (rs == rdRegister)) rsData = wbData;
    if (commit && (rt == rdRegister)) rtData = wbData;
`endif
  end

endmodule
